// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Each accepted command is held on the ALU for HOLD_CYCLES cycles, then its result is returned to the owner.
module alu_share_arbiter #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         cmd_valid0,
   input  logic         cmd_valid1,
   output logic         cmd_ready0,
   output logic         cmd_ready1,
   input  logic [105:0] cmd0,
   input  logic [105:0] cmd1,
   output logic         rsp_valid0,
   output logic         rsp_valid1,
   input  logic         rsp_ready0,
   input  logic         rsp_ready1,
   output logic [31:0]  rsp_data,
   output logic         rsp_zero,
   output logic         busy,
   output logic [2:0]   ALUCtr,
   output logic         ALUSrcA,
   output logic         ALUSrcB,
   output logic [4:0]   shamt,
   output logic [31:0]  ImExtend,
   output logic [31:0]  readData1,
   output logic [31:0]  readData2,
   input  logic [31:0]  ALUData,
   input  logic         zero
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   typedef struct packed {
      logic [2:0]  alu_ctr;
      logic        alu_src_a;
      logic        alu_src_b;
      logic [4:0]  shamt;
      logic [31:0] im_extend;
      logic [31:0] read_data2;
      logic [31:0] read_data1;
   } cmd_t;

   localparam logic [3:0] LAST_CNT = 4'(HOLD_CYCLES - 1);

   state_e      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   cmd_t        drv_q, drv_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_zero_q, rsp_zero_d;
   logic        grant0, grant1;

   // Priority pointer only matters when both requesters are valid together.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (Reset && (state_q == IDLE)) begin
         if (cmd_valid0 && (!cmd_valid1 || !ptr_q)) begin
            grant0 = 1'b1;
         end else if (cmd_valid1) begin
            grant1 = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      drv_d      = drv_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               state_d = EXEC;
               owner_d = grant1;
               cnt_d   = 4'd0;
               drv_d   = grant1 ? cmd_t'(cmd1) : cmd_t'(cmd0);
            end
         end
         EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               rsp_data_d = ALUData;
               rsp_zero_d = zero;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (owner_q ? rsp_ready1 : rsp_ready0) begin
               state_d = IDLE;
               ptr_d   = ~owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= 4'd0;
         drv_q      <= '0;
         rsp_data_q <= 32'd0;
         rsp_zero_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         drv_q      <= drv_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
      end
   end

   assign cmd_ready0 = grant0;
   assign cmd_ready1 = grant1;
   assign rsp_valid0 = (state_q == RESP) && !owner_q;
   assign rsp_valid1 = (state_q == RESP) && owner_q;
   assign busy       = (state_q != IDLE);
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign ALUCtr     = drv_q.alu_ctr;
   assign ALUSrcA    = drv_q.alu_src_a;
   assign ALUSrcB    = drv_q.alu_src_b;
   assign shamt      = drv_q.shamt;
   assign ImExtend   = drv_q.im_extend;
   assign readData1  = drv_q.read_data1;
   assign readData2  = drv_q.read_data2;

endmodule
